// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum and the operand forwarding selects.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULLO   = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int CNT_W = 16;

  // Memory-stage result is younger, so it beats writeback.
  function automatic logic [1:0] fwd_sel(
    input logic hit_m,
    input logic hit_w
  );
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: address-path matches in,
// stall/flush/forward controls and stall counter out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic Match_1E_M;
  logic Match_1E_W;
  logic Match_2E_M;
  logic Match_2E_W;
  logic Match_1D_E;
  logic Match_2D_E;
  logic RegWriteM;
  logic RegWriteW;
  logic MemtoRegE;
  logic BranchTakenE;
  logic MultLongE;
  logic DMemStall;
  logic ClrCount;

  logic StallF;
  logic StallD;
  logic FlushD;
  logic FlushE;
  logic StallE;
  logic StallM;
  logic StallW;
  logic FlushW;
  logic WriteMultLoE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output Match_1E_M, Match_1E_W,
    output Match_2E_M, Match_2E_W,
    output Match_1D_E, Match_2D_E,
    output RegWriteM, RegWriteW,
    output MemtoRegE, BranchTakenE,
    output MultLongE, DMemStall,
    output ClrCount,
    input  StallF, StallD, FlushD,
    input  FlushE, StallE, StallM,
    input  StallW, FlushW,
    input  WriteMultLoE,
    input  ForwardAE, ForwardBE,
    input  StallCycles
  );

  modport slave (
    input  Match_1E_M, Match_1E_W,
    input  Match_2E_M, Match_2E_W,
    input  Match_1D_E, Match_2D_E,
    input  RegWriteM, RegWriteW,
    input  MemtoRegE, BranchTakenE,
    input  MultLongE, DMemStall,
    input  ClrCount,
    output StallF, StallD, FlushD,
    output FlushE, StallE, StallM,
    output StallW, FlushW,
    output WriteMultLoE,
    output ForwardAE, ForwardBE,
    output StallCycles
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable, synchronous clear
// and asynchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall,
// branch flush, long-multiply sequencing and memory wait.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  hazard_ctrl_if.slave hz
);

  hz_state_t state;
  hz_state_t state_nxt;
  hz_state_t eval_st;
  logic      ret_mul;
  logic      ret_nxt;
  logic      ld_stall;

  logic stall_f;
  logic stall_d;
  logic flush_d;
  logic flush_e;
  logic stall_e;
  logic stall_m;
  logic flush_w;
  logic wr_mlo;

  assign hz.ForwardAE = fwd_sel(
    hz.Match_1E_M & hz.RegWriteM,
    hz.Match_1E_W & hz.RegWriteW
  );
  assign hz.ForwardBE = fwd_sel(
    hz.Match_2E_M & hz.RegWriteM,
    hz.Match_2E_W & hz.RegWriteW
  );

  assign ld_stall = hz.MemtoRegE &
    (hz.Match_1D_E | hz.Match_2D_E);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      ret_mul <= 1'b0;
    end else begin
      state   <= state_nxt;
      ret_mul <= ret_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_mul;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_w   = 1'b0;
    wr_mlo    = 1'b0;
    // MEMWAIT behaves as the state it will resume.
    eval_st   = state;
    if (state == MEMWAIT) begin
      eval_st = ret_mul ? MULLO : RUN;
    end

    if (hz.DMemStall) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      stall_m   = 1'b1;
      flush_w   = 1'b1;
      wr_mlo    = (eval_st == MULLO);
      ret_nxt   = (eval_st == MULLO);
      state_nxt = MEMWAIT;
    end else begin
      unique case (eval_st)
        MULLO: begin
          wr_mlo    = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          state_nxt = RUN;
          if (hz.MultLongE) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            state_nxt = MULLO;
          end else if (hz.BranchTakenE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (ld_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign hz.StallF       = stall_f;
  assign hz.StallD       = stall_d;
  assign hz.FlushD       = flush_d;
  assign hz.FlushE       = flush_e;
  assign hz.StallE       = stall_e;
  assign hz.StallM       = stall_m;
  assign hz.StallW       = 1'b0;
  assign hz.FlushW       = flush_w;
  assign hz.WriteMultLoE = wr_mlo;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (stall_f),
    .clr   (hz.ClrCount),
    .count (hz.StallCycles)
  );

endmodule
